// File: rtl/lm32_seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lm32_seq_divider_pkg
//  Purpose  : Shared types and constants for the LM32 sequential divider.
//             Holds the FSM state encoding, the iteration count, the counter
//             width and a two's-complement negate helper.
//  Revision : 1.0  initial release
// ============================================================================
package lm32_seq_divider_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lm32_div_state_e;

  // One restoring step per bit of the 32-bit operand
  localparam int unsigned LM32_DIV_ITERATIONS = 32;
  localparam int unsigned LM32_DIV_CNT_W      = 5;

  // The counter is loaded with N-1 and counts down to 0, giving N steps
  localparam logic [LM32_DIV_CNT_W-1:0] LM32_DIV_CNT_INIT =
    LM32_DIV_CNT_W'(LM32_DIV_ITERATIONS - 1);

  // Two's-complement negate
  function automatic logic [31:0] lm32_neg(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Conditional negate: magnitude extraction and sign correction share this
  function automatic logic [31:0] lm32_cond_neg(input logic neg, input logic [31:0] v);
    return neg ? lm32_neg(v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lm32_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : lm32_addsub
//  Purpose  : 32-bit adder/subtractor with carry in and carry out.
//  Ports    : DataA, DataB  operands
//             Cin           carry in (1 with Add_Sub=0 gives A-B)
//             Add_Sub       1 = add, 0 = subtract (B is inverted)
//             Result        32-bit sum/difference
//             Cout          carry out; in subtract mode 1 means no borrow
//  Revision : 1.0  initial release
// ============================================================================
module lm32_addsub (
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic        Cin,
  input  logic        Add_Sub,
  output logic [31:0] Result,
  output logic        Cout
);

  logic [31:0] w_opb;
  logic [32:0] w_sum;

  assign w_opb  = Add_Sub ? DataB : ~DataB;
  assign w_sum  = {1'b0, DataA} + {1'b0, w_opb} + {32'd0, Cin};
  assign Result = w_sum[31:0];
  assign Cout   = w_sum[32];

endmodule
`default_nettype wire

// File: rtl/lm32_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : lm32_seq_divider
//  Purpose  : 32-bit sequential restoring divider (signed/unsigned), one
//             quotient bit per cycle, 34-cycle latency from accepted start to
//             result_valid_o.
//  Ports    : clk_i, rst_i (sync, active high)
//             start_i, sign_i, kill_i      control
//             dividend_i, divisor_i        operands
//             quotient_o, remainder_o      results, held until next start
//             result_valid_o               one-cycle result strobe
//             busy_o                       pipeline stall request
//             divide_by_zero_o             one-cycle divide-by-zero strobe
//  Revision : 1.0  initial release
// ============================================================================
module lm32_seq_divider
  import lm32_seq_divider_pkg::*;
#(
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        sign_i,
  input  logic        kill_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        result_valid_o,
  output logic        busy_o,
  output logic        divide_by_zero_o
);

  lm32_div_state_e             state_q, state_d;
  logic [LM32_DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]                 rem_q, rem_d;       // partial remainder
  logic [31:0]                 quo_q, quo_d;       // dividend bits out, quotient bits in
  logic [31:0]                 dvs_q, dvs_d;       // divisor magnitude
  logic                        qneg_q, qneg_d;
  logic                        rneg_q, rneg_d;
  logic [31:0]                 quotient_q, quotient_d;
  logic [31:0]                 remainder_q, remainder_d;
  logic                        dbz_q, dbz_d;

  logic        w_signed;
  logic [31:0] w_shifted;
  logic [31:0] w_diff;
  logic        w_cout;
  logic        w_step_ok;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  assign w_signed = SIGNED_SUPPORT & sign_i;

  // Shift the partial remainder left, pulling in the next dividend MSB.
  // rem_q[31] is the bit shifted out; if it is set the 33-bit value is
  // already >= divisor, so the step succeeds regardless of the carry.
  assign w_shifted = {rem_q[30:0], quo_q[31]};

  lm32_addsub u_trial_sub (
    .DataA   (w_shifted),
    .DataB   (dvs_q),
    .Cin     (1'b1),
    .Add_Sub (1'b0),
    .Result  (w_diff),
    .Cout    (w_cout)
  );

  assign w_step_ok  = rem_q[31] | w_cout;
  assign w_rem_next = w_step_ok ? w_diff : w_shifted;
  assign w_quo_next = {quo_q[30:0], w_step_ok};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // kill_i wins over a simultaneous start
        if (start_i && !kill_i) begin
          if (divisor_i == 32'd0) begin
            dbz_d = 1'b1;
          end else begin
            rem_d   = '0;
            quo_d   = lm32_cond_neg(w_signed & dividend_i[31], dividend_i);
            dvs_d   = lm32_cond_neg(w_signed & divisor_i[31], divisor_i);
            qneg_d  = w_signed & (dividend_i[31] ^ divisor_i[31]);
            rneg_d  = w_signed & dividend_i[31];
            cnt_d   = LM32_DIV_CNT_INIT;
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        if (kill_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = w_rem_next;
          quo_d = w_quo_next;
          if (cnt_q == '0) begin
            // Final step: sign-correct into the output registers so the
            // results are presented, stable, throughout the DONE cycle.
            quotient_d  = lm32_cond_neg(qneg_q, w_quo_next);
            remainder_d = lm32_cond_neg(rneg_q, w_rem_next);
            state_d     = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign quotient_o       = quotient_q;
  assign remainder_o      = remainder_q;
  assign result_valid_o   = (state_q == ST_DONE) & ~kill_i;
  assign busy_o           = (state_q == ST_BUSY) | (state_q == ST_DONE);
  assign divide_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_lm32_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lm32_seq_divider
//  Purpose  : Scoreboard bench for lm32_seq_divider with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lm32_seq_divider;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        sign_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        result_valid_o;
  logic        busy_o;
  logic        divide_by_zero_o;

  lm32_seq_divider #(.SIGNED_SUPPORT(1'b1)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .sign_i           (sign_i),
    .kill_i           (kill_i),
    .dividend_i       (dividend_i),
    .divisor_i        (divisor_i),
    .quotient_o       (quotient_o),
    .remainder_o      (remainder_o),
    .result_valid_o   (result_valid_o),
    .busy_o           (busy_o),
    .divide_by_zero_o (divide_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic        dbz;
    logic [31:0] q;
    logic [31:0] r;
    int          at;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output strobe must match the oldest expected response
  always @(negedge clk_i) begin
    if (!rst_i && (result_valid_o || divide_by_zero_o)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe valid=%b dbz=%b at cycle %0d", result_valid_o,
                 divide_by_zero_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_kind", {30'd0, result_valid_o, divide_by_zero_o}, {30'd0, ~e.dbz, e.dbz});
        chk("strobe_cycle", cyc, e.at);
        if (!e.dbz) begin
          chk("quotient", quotient_o, e.q);
          chk("remainder", remainder_o, e.r);
        end
      end
    end
  end

  // Advance to 1 time unit after the edge that begins cycle t
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Issue a start in the current cycle; returns the start cycle
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it, input logic [31:0] q, input logic [31:0] r,
                       output int c);
    exp_t e;
    c          = cyc;
    start_i    = 1'b1;
    sign_i     = sgn;
    dividend_i = a;
    divisor_i  = b;
    if (expect_it) begin
      e.dbz = (b == 32'd0);
      e.q   = q;
      e.r   = r;
      e.at  = (b == 32'd0) ? c + 1 : c + 33;
      sb.push_back(e);
    end
    goto(c + 1);
    start_i = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_quotient"}, quotient_o, 32'd0);
    chk({tag, "_remainder"}, remainder_o, 32'd0);
    chk({tag, "_valid"}, {31'd0, result_valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, divide_by_zero_o}, 32'd0);
  endtask

  initial begin
    int c;
    goto(3);
    chk_zero_outputs("reset");
    rst_i = 1'b0;
    goto(5);

    // Unsigned 100/7 with latency and busy window checks
    chk("busy_before_start", {31'd0, busy_o}, 32'd0);
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, c);
    chk("busy_c1", {31'd0, busy_o}, 32'd1);
    goto(c + 32);
    chk("busy_c32", {31'd0, busy_o}, 32'd1);
    goto(c + 33);
    chk("busy_c33", {31'd0, busy_o}, 32'd1);
    goto(c + 34);
    chk("busy_c34", {31'd0, busy_o}, 32'd0);
    goto(c + 40);
    chk("hold_quotient", quotient_o, 32'd14);
    chk("hold_remainder", remainder_o, 32'd2);

    // Signed -7/2 and the overflow-like corner case
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, c);
    goto(c + 36);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, c);
    goto(c + 36);

    // Divide by zero: strobe at c+1 only, never busy
    issue(1'b0, 32'h0000_1234, 32'd0, 1'b1, 32'd0, 32'd0, c);
    chk("dbz_busy_c1", {31'd0, busy_o}, 32'd0);
    goto(c + 2);
    chk("dbz_busy_c2", {31'd0, busy_o}, 32'd0);
    chk("dbz_c2_low", {31'd0, divide_by_zero_o}, 32'd0);
    goto(c + 5);

    // Kill at cycle 10, then a fresh operation
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, c);
    goto(c + 10);
    chk("kill_busy_c10", {31'd0, busy_o}, 32'd1);
    kill_i = 1'b1;
    goto(c + 11);
    kill_i = 1'b0;
    chk("kill_busy_c11", {31'd0, busy_o}, 32'd0);
    goto(c + 40);
    issue(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b1, 32'h5555_5555, 32'd0, c);
    goto(c + 36);

    // A start during BUSY must be ignored
    issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, c);
    goto(c + 5);
    start_i    = 1'b1;
    sign_i     = 1'b1;
    dividend_i = 32'd77;
    divisor_i  = 32'd7;
    goto(c + 6);
    start_i = 1'b0;
    goto(c + 36);

    // Reset mid-operation clears everything
    issue(1'b0, 32'h1234_5678, 32'h10, 1'b0, 32'd0, 32'd0, c);
    goto(c + 20);
    rst_i = 1'b1;
    goto(c + 21);
    rst_i = 1'b0;
    chk_zero_outputs("midreset");
    goto(c + 60);
    chk("after_reset_quiet", {31'd0, busy_o}, 32'd0);

    // Recovery after reset: signed -9/4
    issue(1'b1, 32'hFFFF_FFF7, 32'd4, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, c);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk_i);
      #1;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    goto(cyc + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lm32_seq_divider.md
LM32_SEQ_DIVIDER -- requirements
Module: lm32_seq_divider

Interface
REQ-001 SHALL have parameter SIGNED_SUPPORT, default 1; 1 enables signed divide/modulus, 0 forces the sign_i input to 0.
REQ-002 SHALL have clk_i  input  1  clock; single clock domain.
REQ-003 SHALL have rst_i  input  1  synchronous active-high reset.
REQ-004 SHALL have start_i  input  1  one-cycle request to begin an operation.
REQ-005 SHALL have sign_i  input  1  1 = signed operands (two's complement), 0 = unsigned.
REQ-006 SHALL have kill_i  input  1  abort the current operation.
REQ-007 SHALL have dividend_i  input  32  dividend (operand 0).
REQ-008 SHALL have divisor_i  input  32  divisor (operand 1).
REQ-009 SHALL have quotient_o  output  32  quotient result.
REQ-010 SHALL have remainder_o  output  32  remainder result.
REQ-011 SHALL have result_valid_o  output  1  one-cycle strobe; both results are valid.
REQ-012 SHALL have busy_o  output  1  high while an operation is in progress (stall request to the pipeline).
REQ-013 SHALL have divide_by_zero_o  output  1  one-cycle strobe; divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL accept start_i only in IDLE; start_i in BUSY or DONE SHALL be ignored.
REQ-016 SHALL, on an accepted start with divisor_i==0, assert divide_by_zero_o in the next cycle, stay in IDLE, and not assert result_valid_o.
REQ-017 SHALL, on an accepted start with a nonzero divisor, latch the operand magnitudes (signed mode: absolute values), latch the quotient sign (sign_dividend XOR sign_divisor) and the remainder sign (sign_dividend), load the iteration counter with 31, and enter BUSY.
REQ-018 SHALL perform one restoring-division step per BUSY cycle, for 32 cycles in total.
- Step: shift the partial remainder left by one, bringing in the next dividend MSB.
- Trial-subtract the divisor.
- The step succeeds if the shifted-out bit is 1 or the subtractor carry-out is 1 (no borrow).
- On success, write back the difference and shift 1 into the quotient; otherwise keep the shifted value and shift 0 in.
REQ-019 SHALL enter DONE when the counter reaches 0 in BUSY; in DONE, apply the sign corrections (two's-complement negate where the latched sign is 1), assert result_valid_o for exactly one cycle, then return to IDLE.
REQ-020 SHALL have a total latency of 34 cycles: start_i accepted at cycle 0 gives result_valid_o at cycle 33.
REQ-021 SHALL assert busy_o from the cycle after an accepted start through the DONE cycle inclusive.
REQ-022 SHALL hold quotient_o and remainder_o stable from DONE until the next accepted start.
REQ-023 SHALL, in signed mode, return quotient 0x80000000 and remainder 0 for 0x80000000 / 0xFFFFFFFF, with no error flag.
REQ-024 SHALL truncate the signed quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-025 SHALL, when kill_i is asserted in BUSY or DONE, return to IDLE on the next edge, suppress result_valid_o, and deassert busy_o.
REQ-026 SHALL give kill_i priority over start_i when both are asserted in IDLE; the start is dropped.

Reset
REQ-027 SHALL, on rst_i at a clock edge, enter IDLE regardless of state, including mid-operation.
REQ-028 SHALL reset quotient_o=0, remainder_o=0, result_valid_o=0, busy_o=0, divide_by_zero_o=0 and the counter to 0.
REQ-029 SHALL give rst_i priority over kill_i and start_i.

Structure
REQ-030 SHALL place the FSM state encodings (2-bit), the iteration count constant (32) and the counter width (5) in the shared lm32 include/package.
REQ-031 SHALL instantiate lm32_addsub exactly once as the trial subtractor:
- Add_Sub=0, Cin=1.
- DataA = shifted partial remainder [31:0]; DataB = divisor.
- Cout = no-borrow indication.
REQ-032 SHALL implement sign correction with a separate negate path, not a second lm32_addsub instance.

Verification
REQ-033 SHALL be verified with unsigned 100/7, start at cycle 0 -> result_valid_o at cycle 33, quotient 14, remainder 2.
REQ-034 SHALL be verified with signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-035 SHALL be verified with signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, divide_by_zero_o=0.
REQ-036 SHALL be verified with divisor 0, any dividend -> divide_by_zero_o high at cycle 1 only, busy_o never high, no result_valid_o.
REQ-037 SHALL be verified with:
- unsigned 0xFFFFFFFF / 1, kill_i at cycle 10 -> no result_valid_o, busy_o low at cycle 11;
- then a new start of 0xFFFFFFFF / 3 -> quotient 0x55555555, remainder 0, 33 cycles later.
REQ-038 SHALL be verified with rst_i at cycle 20 of an operation and a second start_i during BUSY -> all outputs 0 after reset, and the ignored start does not alter the running result.
